// File: rtl/qdec_bitstream_fifo_pkg.sv
// rtl/qdec_bitstream_fifo_pkg.sv - shared constants and types for the CABAC bitstream FIFO
package qdec_cabac_package;

  localparam int QDEC_BS_IN_BYTES_DEF = 4;
  localparam int QDEC_BS_DEPTH_DEF    = 1024;
  localparam int QDEC_BS_ADDR_W_DEF   = $clog2(QDEC_BS_DEPTH_DEF);

  // Fill level for the default ring depth (one extra bit so a full ring is representable)
  typedef logic [QDEC_BS_ADDR_W_DEF:0] t_bs_level;

  // Byte inserted by the encoder after two zero bytes to prevent start-code emulation
  localparam logic [7:0] QDEC_EPB_BYTE = 8'h03;

endpackage

// File: rtl/qdec_bitstream_fifo_epb_filter.sv
// rtl/qdec_bitstream_fifo_epb_filter.sv - EPB removal between ring head and output (QDEC_BITSTREAM_EPB_REMOVE_EN)
`ifdef QDEC_BITSTREAM_EPB_REMOVE_EN
module qdec_bs_epb_filter
  import qdec_cabac_package::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        headVld,
  input  logic [7:0]  headByte,
  input  logic        popOk,
  output logic        drop,
  output logic [15:0] epb_cnt
);

  logic [1:0] zrun;

  // An 03 following exactly two delivered zeros is an emulation-prevention byte
  assign drop = headVld && (headByte == QDEC_EPB_BYTE) && (zrun == 2'd2);

  // Saturating run length of zero bytes handed to the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zrun <= 2'd0;
    end else if (flush || drop) begin
      zrun <= 2'd0;
    end else if (popOk) begin
      if (headByte != 8'h00) begin
        zrun <= 2'd0;
      end else if (zrun != 2'd3) begin
        zrun <= zrun + 2'd1;
      end
    end
  end

  // Removed-EPB counter; survives flush so software can read totals across streams
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epb_cnt <= 16'h0000;
    end else if (!flush && drop && (epb_cnt != 16'hFFFF)) begin
      epb_cnt <= epb_cnt + 16'h0001;
    end
  end

endmodule
`endif

// File: rtl/qdec_bitstream_fifo.sv
// rtl/qdec_bitstream_fifo.sv - beat-to-byte ring FIFO feeding qdec_cabac, optional EPB removal via QDEC_BITSTREAM_EPB_REMOVE_EN
module qdec_bitstream_fifo
  import qdec_cabac_package::*;
#(
  parameter  int IN_BYTES = QDEC_BS_IN_BYTES_DEF,
  parameter  int DEPTH    = QDEC_BS_DEPTH_DEF,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int NB_W     = $clog2(IN_BYTES) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [IN_BYTES*8-1:0] din,
  input  logic [NB_W-1:0]       din_nbytes,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [7:0]            dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [ADDR_W:0]       level,
  output logic                  empty,
  output logic                  full,
  output logic [15:0]           epb_cnt
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic              nbValid;
  logic              push;
  logic              pop;
  logic              drop;
  logic              rdAdv;
  logic              headVld;
  logic [7:0]        headByte;
  logic [ADDR_W:0]   pushCnt;

  assign nbValid  = (din_nbytes != '0) && (int'(din_nbytes) <= IN_BYTES);
  assign full     = (int'(level) > (DEPTH - IN_BYTES));
  assign empty    = (level == '0);
  assign din_rdy  = !full && !flush;
  assign push     = din_vld && din_rdy && nbValid;
  assign pushCnt  = push ? (ADDR_W+1)'(din_nbytes) : '0;

  assign headVld  = !empty;
  assign headByte = mem[rdPtr];
  assign dout     = headVld ? headByte : 8'h00;
  assign dout_vld = headVld && !drop;
  assign pop      = dout_vld && dout_rdy;
  assign rdAdv    = pop || drop;

`ifdef QDEC_BITSTREAM_EPB_REMOVE_EN
  qdec_bs_epb_filter uEpbFilter (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .headVld  (headVld),
    .headByte (headByte),
    .popOk    (pop),
    .drop     (drop),
    .epb_cnt  (epb_cnt)
  );
`else
  assign drop    = 1'b0;
  assign epb_cnt = 16'h0000;
`endif

  // Pointer and level bookkeeping; flush discards any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      wrPtr <= wrPtr + ADDR_W'(pushCnt);
      rdPtr <= rdPtr + ADDR_W'(rdAdv);
      level <= level + pushCnt - (ADDR_W+1)'(rdAdv);
    end
  end

  // Byte-lane writes; pointer arithmetic wraps so straddling beats split across the ring end
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < IN_BYTES; i++) begin
        if (i < int'(din_nbytes)) begin
          mem[wrPtr + ADDR_W'(i)] <= din[8*i +: 8];
        end
      end
    end
  end

  // Out-of-range byte counts are swallowed silently in hardware; make them loud in simulation
  always_ff @(posedge clk) begin
    if (rst_n && din_vld && din_rdy) begin
      assert (nbValid) else $error("qdec_bitstream_fifo: din_nbytes out of range");
    end
  end

endmodule

// File: tb/tb_qdec_bitstream_fifo.sv
// tb/tb_qdec_bitstream_fifo.sv - queue-model randomized and directed bench for qdec_bitstream_fifo
module tb_qdec_bitstream_fifo;

  localparam int IN_BYTES = 4;
  localparam int DEPTH    = 16;

`ifdef QDEC_BITSTREAM_EPB_REMOVE_EN
  localparam bit EPB = 1'b1;
`else
  localparam bit EPB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] din = '0;
  logic [2:0]  din_nbytes = 3'd1;
  logic        din_vld = 1'b0;
  logic        din_rdy;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        dout_rdy = 1'b0;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic [15:0] epb_cnt;

  int total = 0;
  int bad   = 0;

  byte unsigned q[$];
  byte unsigned outQ[$];
  int zr   = 0;
  int ecnt = 0;

  always #5 clk = ~clk;

  qdec_bitstream_fifo #(.IN_BYTES(IN_BYTES), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .din        (din),
    .din_nbytes (din_nbytes),
    .din_vld    (din_vld),
    .din_rdy    (din_rdy),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .epb_cnt    (epb_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check against model, advance model across posedge
  task automatic step(input bit fl, input bit vld, input logic [31:0] d, input int nb, input bit rdy);
    int lvl;
    bit fullM, dropM, vldM;
    byte unsigned b;
    flush = fl; din_vld = vld; din = d; din_nbytes = 3'(nb); dout_rdy = rdy;
    #1;
    lvl   = q.size();
    fullM = (DEPTH - lvl) < IN_BYTES;
    dropM = EPB && (lvl != 0) && (q[0] == 8'h03) && (zr == 2);
    vldM  = (lvl != 0) && !dropM;
    chk("level", level, lvl);
    chk("empty", empty, lvl == 0);
    chk("full", full, fullM);
    chk("din_rdy", din_rdy, !fullM && !fl);
    chk("dout_vld", dout_vld, vldM);
    if (vldM) chk("dout", dout, q[0]);
    else if (lvl == 0) chk("dout_idle", dout, 0);
    chk("epb_cnt", epb_cnt, ecnt);
    if (fl) begin
      q.delete();
      zr = 0;
    end else begin
      if (vldM && rdy) begin
        b = q.pop_front();
        outQ.push_back(b);
        zr = (b == 0) ? ((zr < 3) ? zr + 1 : 3) : 0;
      end else if (dropM) begin
        void'(q.pop_front());
        zr = 0;
        if (ecnt < 65535) ecnt++;
      end
      if (vld && !fullM) begin
        for (int i = 0; i < nb; i++) q.push_back(d[8*i +: 8]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 32'h0, 1, rdy);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && q.size() != 0; k++) idle(1'b1);
    chk("drain_level", level, 0);
  endtask

  // Asynchronous reset applied away from the clock edge; effect must be immediate
  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dout_vld", dout_vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_full", full, 0);
    chk("rst_din_rdy", din_rdy, 1);
    chk("rst_epb_cnt", epb_cnt, 0);
    q.delete(); zr = 0; ecnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rb();
    case ($urandom_range(0, 3))
      0, 1:    return 8'h00;
      2:       return 8'h03;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] expT1 [4];
    logic [7:0] expWrap [4];
    logic [7:0] expEpb [$];
    logic [31:0] rd;
    expT1   = '{8'h11, 8'h22, 8'h33, 8'h44};
    expWrap = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    @(negedge clk);
    do_reset();

    // Single beat streams out on consecutive cycles
    outQ.delete();
    step(1'b0, 1'b1, 32'h44332211, 4, 1'b1);
    for (int k = 0; k < 5; k++) idle(1'b1);
    chk("t1_count", outQ.size(), 4);
    for (int i = 0; i < 4 && i < outQ.size(); i++) chk($sformatf("t1_b%0d", i), outQ[i], expT1[i]);

    // Fill to full, then try pop+push while full
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h10203040 + k, 4, 1'b0);
    chk("full_level", level, 16);
    step(1'b0, 1'b1, 32'h00000055, 1, 1'b1);
    drain();

    // Wrap: move pointers to 14, then push a straddling beat
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'h15161718, 4, 1'b0);
    step(1'b0, 1'b1, 32'h00001919, 2, 1'b0);
    drain();
    outQ.delete();
    step(1'b0, 1'b1, 32'hDDCCBBAA, 4, 1'b0);
    drain();
    chk("wrap_count", outQ.size(), 4);
    for (int i = 0; i < 4 && i < outQ.size(); i++) chk($sformatf("wrap_b%0d", i), outQ[i], expWrap[i]);

    // Partial beat
    outQ.delete();
    step(1'b0, 1'b1, 32'hEEFF0201, 2, 1'b0);
    chk("partial_level", level, 2);
    drain();
    chk("partial_count", outQ.size(), 2);
    if (outQ.size() == 2) begin
      chk("partial_b0", outQ[0], 8'h01);
      chk("partial_b1", outQ[1], 8'h02);
    end

    // Flush at level 9 with a beat offered
    step(1'b0, 1'b1, 32'h21222324, 4, 1'b0);
    step(1'b0, 1'b1, 32'h25262728, 4, 1'b0);
    step(1'b0, 1'b1, 32'h00000029, 1, 1'b0);
    chk("flush_pre_level", level, 9);
    step(1'b1, 1'b1, 32'h31323334, 4, 1'b0);
    chk("flush_level", level, 0);
    chk("flush_dout_vld", dout_vld, 0);
    idle(1'b1);

    // Emulation-prevention stream
    do_reset();
    outQ.delete();
    step(1'b0, 1'b1, 32'h01030000, 4, 1'b1);
    step(1'b0, 1'b1, 32'h03030000, 4, 1'b1);
    drain();
    if (EPB) expEpb = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h03};
    else     expEpb = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h03, 8'h03};
    chk("epb_count", outQ.size(), expEpb.size());
    for (int i = 0; i < expEpb.size() && i < outQ.size(); i++) chk($sformatf("epb_b%0d", i), outQ[i], expEpb[i]);
    chk("epb_cnt_final", epb_cnt, EPB ? 2 : 0);

    // Randomized traffic against the queue model
    for (int k = 0; k < 3000; k++) begin
      rd = {rb(), rb(), rb(), rb()};
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, rd,
           $urandom_range(1, IN_BYTES), $urandom_range(0, 9) < 6);
      if (k == 1500) do_reset();
    end
    drain();

    // Reset mid-operation
    step(1'b0, 1'b1, 32'h0A0B0C0D, 4, 1'b0);
    step(1'b0, 1'b1, 32'h0E0F0102, 3, 1'b0);
    do_reset();
    idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
